// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: hex seven-segment controller with handshake load, frame-aligned commit,
// static and multiplexed outputs, leading-zero blanking and per-digit blink.
module hex_display_ctrl #(
    parameter int DIGITS   = 8,
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*DIGITS-1:0] load_data,
    input  logic                blank_lz_en,
    input  logic [DIGITS-1:0]   blink_mask,
    output logic [7*DIGITS-1:0] seg_par,
    output logic [6:0]          seg_scan,
    output logic [DIGITS-1:0]   an_n,
    output logic                blink_phase
);
    localparam int SCAN_DIV  = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int IW = $clog2(DIGITS);

    if (SCAN_DIV < 1 || BLINK_DIV < 1 || DIGITS < 2 || DIGITS > 16) begin : g_bad_cfg
        $error("hex_display_ctrl: invalid DIGITS or clock dividers");
    end

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

    state_t              state, state_nx;
    logic [SW-1:0]       scan_cnt;
    logic [BW-1:0]       blink_cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow, disp_reg;
    logic [7*DIGITS-1:0] seg_nx;
    logic                disp_vld, live, scan_tick, blink_tick, frame_end, nz;
    logic [3:0]          nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b100_0000;
            4'h1: hex7 = 7'b111_1001;
            4'h2: hex7 = 7'b010_0100;
            4'h3: hex7 = 7'b011_0000;
            4'h4: hex7 = 7'b001_1001;
            4'h5: hex7 = 7'b001_0010;
            4'h6: hex7 = 7'b000_0010;
            4'h7: hex7 = 7'b111_1000;
            4'h8: hex7 = 7'b000_0000;
            4'h9: hex7 = 7'b001_0000;
            4'hA: hex7 = 7'b000_1000;
            4'hB: hex7 = 7'b000_0011;
            4'hC: hex7 = 7'b100_0110;
            4'hD: hex7 = 7'b010_0001;
            4'hE: hex7 = 7'b000_0110;
            default: hex7 = 7'b000_1110;
        endcase
    endfunction

    assign scan_tick  = scan_cnt == SW'(SCAN_DIV - 1);
    assign blink_tick = blink_cnt == BW'(BLINK_DIV - 1);
    assign frame_end  = scan_tick && idx == IW'(DIGITS - 1);
    // ready is held low until the first clock after reset release
    assign load_ready = live && state == IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (load_valid && load_ready) ? PENDING : IDLE;
            PENDING: state_nx = frame_end ? COMMIT : PENDING;
            default: state_nx = IDLE;
        endcase
    end

    // Scan from the top digit down so nz means "some digit at or above k is nonzero"
    always_comb begin
        seg_nx = '1;
        nz     = 1'b0;
        nib    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = disp_reg[4*k +: 4];
            nz  = nz | (nib != 4'h0);
            seg_nx[7*k +: 7] = (!disp_vld || (blank_lz_en && !nz && k != 0) ||
                                (blink_mask[k] && blink_phase)) ? 7'h7F : hex7(nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            live        <= 1'b0;
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            idx         <= '0;
            blink_phase <= 1'b0;
            shadow      <= '0;
            disp_reg    <= '0;
            disp_vld    <= 1'b0;
            seg_par     <= '1;
            seg_scan    <= '1;
            an_n        <= '1;
        end else begin
            state       <= state_nx;
            live        <= 1'b1;
            scan_cnt    <= scan_tick ? '0 : scan_cnt + 1'b1;
            blink_cnt   <= blink_tick ? '0 : blink_cnt + 1'b1;
            blink_phase <= blink_phase ^ blink_tick;
            if (scan_tick)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            if (load_valid && load_ready)
                shadow <= load_data;
            if (state == COMMIT) begin
                disp_reg <= shadow;
                disp_vld <= 1'b1;
            end
            seg_par  <= seg_nx;
            seg_scan <= seg_nx[7*int'(idx) +: 7];
            an_n     <= ~(DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed checks of load handshake, frame commit, blanking, blink,
// scan bus and reset behaviour for a 4-digit configuration.
module tb_hex_display_ctrl;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0, blank_lz_en = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  blink_mask = '0;
    logic        load_ready, blink_phase;
    logic [27:0] seg_par;
    logic [6:0]  seg_scan;
    logic [3:0]  an_n;
    int          cyc, n_checks = 0, n_errors = 0;

    hex_display_ctrl #(.DIGITS(4), .CLK_HZ(400), .SCAN_HZ(10), .BLINK_HZ(20)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .blank_lz_en(blank_lz_en), .blink_mask(blink_mask),
        .seg_par(seg_par), .seg_scan(seg_scan), .an_n(an_n), .blink_phase(blink_phase));

    always #5 clk = ~clk;

    // cycles since reset release; mirrors the divider phase seen at the ports
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] s(input int h);
        return SEG[h];
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        int k = 0;
        while (!load_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_load", {31'b0, load_ready}, 1);
        load_valid = 1'b1;
        load_data  = v;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_commit();
        int k = 0;
        while (!load_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("commit_timeout", {31'b0, load_ready}, 1);
        @(negedge clk);
    endtask

    initial begin
        int t, acc;
        logic ph;
        #12;
        check("rst_ready", {31'b0, load_ready}, 0);
        check("rst_seg_par", {4'b0, seg_par}, 28'hFFFFFFF);
        check("rst_seg_scan", {25'b0, seg_scan}, 7'h7F);
        check("rst_an_n", {28'b0, an_n}, 4'hF);
        check("rst_blink", {31'b0, blink_phase}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", {31'b0, load_ready}, 1);
        check("blank_before_load", {4'b0, seg_par}, 28'hFFFFFFF);

        load(16'h12AF);
        wait_commit();
        check("disp_12AF", {4'b0, seg_par}, {4'b0, s(1), s(2), s(10), s(15)});
        check("ready_after_commit", {31'b0, load_ready}, 1);

        blank_lz_en = 1'b1;
        load(16'h0030);
        wait_commit();
        check("lz_0030", {4'b0, seg_par}, {4'b0, BL, BL, s(3), s(0)});
        load(16'h0000);
        wait_commit();
        check("lz_0000", {4'b0, seg_par}, {4'b0, BL, BL, BL, s(0)});
        blank_lz_en = 1'b0;
        repeat (2) @(negedge clk);
        check("nolz_0000", {4'b0, seg_par}, {4'b0, s(0), s(0), s(0), s(0)});
        load(16'h0030);
        wait_commit();
        check("nolz_0030", {4'b0, seg_par}, {4'b0, s(0), s(0), s(3), s(0)});

        // load presented exactly on a frame_end cycle
        t = cyc + ((39 - cyc % 40 + 40) % 40);
        wait_cyc(t);
        load_valid = 1'b1;
        load_data  = 16'h5A5A;
        @(negedge clk);
        acc = cyc;
        load_data = 16'h0F0F;
        check("pend_ready_lo", {31'b0, load_ready}, 0);
        wait_cyc(acc + 3);
        load_valid = 1'b0;
        wait_cyc(acc + 39);
        check("pend_ready_39", {31'b0, load_ready}, 0);
        check("pend_old_39", {4'b0, seg_par}, {4'b0, s(0), s(0), s(3), s(0)});
        wait_cyc(acc + 40);
        check("commit_ready_40", {31'b0, load_ready}, 0);
        wait_cyc(acc + 41);
        check("idle_ready_41", {31'b0, load_ready}, 1);
        check("old_41", {4'b0, seg_par}, {4'b0, s(0), s(0), s(3), s(0)});
        wait_cyc(acc + 42);
        check("new_42", {4'b0, seg_par}, {4'b0, s(5), s(10), s(5), s(10)});

        blink_mask = 4'b0001;
        load(16'h4321);
        wait_commit();
        t = (cyc / 10 + 1) * 10;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(t + 10 * i);
            ph = ((t + 10 * i) / 10) % 2 == 1;
            check("blink_phase", {31'b0, blink_phase}, {31'b0, ph});
            check("blink_pre", {4'b0, seg_par}, {4'b0, s(4), s(3), s(2), !ph ? BL : s(1)});
            wait_cyc(t + 10 * i + 1);
            check("blink_post", {4'b0, seg_par}, {4'b0, s(4), s(3), s(2), ph ? BL : s(1)});
        end

        blink_mask = 4'b0000;
        t = cyc + 2;
        t = t + ((41 - t % 40) % 40);
        for (int j = 0; j < 4; j++) begin
            wait_cyc(t + 10 * j);
            check("scan_an", {28'b0, an_n}, {28'b0, ~(4'b0001 << j)});
            check("scan_seg", {25'b0, seg_scan}, {25'b0, s(j + 1)});
            wait_cyc(t + 10 * j + 9);
            check("scan_hold", {28'b0, an_n}, {28'b0, ~(4'b0001 << j)});
        end

        load(16'hBEEF);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_seg_par", {4'b0, seg_par}, 28'hFFFFFFF);
        check("mid_rst_seg_scan", {25'b0, seg_scan}, 7'h7F);
        check("mid_rst_an_n", {28'b0, an_n}, 4'hF);
        check("mid_rst_ready", {31'b0, load_ready}, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (10) @(negedge clk);
            check("no_beef", {4'b0, seg_par}, 28'hFFFFFFF);
        end
        blank_lz_en = 1'b1;
        load(16'h0007);
        wait_commit();
        check("after_rst_load", {4'b0, seg_par}, {4'b0, BL, BL, BL, s(7)});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
